// File: rtl/change_dispenser_if.sv
// Change-request handshake between the vending FSM and the dispenser.
// master: drives req_valid/req_amt; slave: returns req_ready.
interface change_dispenser_if;
  logic       req_valid;
  logic [3:0] req_amt;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_amt,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_amt,
    output req_ready
  );
endinterface

// File: rtl/change_dispenser_ctrl.sv
// Coin-change dispenser sequencer: dimes first, nickels as fallback.
// Ports: clk/reset, req (slave handshake), coin_sensed, refill_*,
//   eject_*, busy, done, fault, owed, nickel_cnt, dime_cnt.
module change_dispenser_ctrl #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NICKEL_INIT    = 15,
  parameter int DIME_INIT      = 15
) (
  input  logic                clk,
  input  logic                reset,
  change_dispenser_if.slave   req,
  input  logic                coin_sensed,
  input  logic                refill_nickel,
  input  logic                refill_dime,
  output logic                eject_nickel,
  output logic                eject_dime,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [3:0]          owed,
  output logic [4:0]          nickel_cnt,
  output logic [4:0]          dime_cnt
);

  localparam int PW =
    (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    NI     = 5'(NICKEL_INIT);
  localparam logic [4:0]    DI     = 5'(DIME_INIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t        r_state;
  logic [3:0]    r_owed;
  logic [4:0]    r_nick;
  logic [4:0]    r_dime;
  logic [PW-1:0] r_pulse;
  logic [TW-1:0] r_tmo;
  logic          r_is_dime;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owed    <= '0;
      r_nick    <= NI;
      r_dime    <= DI;
      r_pulse   <= '0;
      r_tmo     <= '0;
      r_is_dime <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (refill_nickel) r_nick <= NI;
          if (refill_dime)   r_dime <= DI;
          if (req.req_valid) begin
            if (req.req_amt == 4'd0) begin
              r_state <= S_DONE;
            end else begin
              r_owed  <= req.req_amt;
              r_state <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          r_pulse <= '0;
          if (r_owed == 4'd0) begin
            r_state <= S_DONE;
          end else if (r_owed >= 4'd2 && r_dime != 5'd0) begin
            r_is_dime <= 1'b1;
            r_state   <= S_EJECT;
          end else if (r_nick != 5'd0) begin
            r_is_dime <= 1'b0;
            r_state   <= S_EJECT;
          end else begin
            // owed=1 with no nickels: never overpay with a dime
            r_state <= S_FAULT;
          end
        end
        S_EJECT: begin
          if (r_pulse == P_LAST) begin
            r_pulse <= '0;
            r_tmo   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_pulse <= r_pulse + 1'b1;
          end
        end
        S_WAIT: begin
          if (coin_sensed) begin
            if (r_is_dime) begin
              r_dime <= r_dime - 5'd1;
              r_owed <= r_owed - 4'd2;
            end else begin
              r_nick <= r_nick - 5'd1;
              r_owed <= r_owed - 4'd1;
            end
            r_state <= S_SELECT;
          end else if (r_tmo == T_LAST) begin
            r_state <= S_FAULT;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_FAULT: begin
          if (refill_nickel) r_nick <= NI;
          if (refill_dime)   r_dime <= DI;
          // refill resumes the held request
          if (refill_nickel || refill_dime)
            r_state <= S_SELECT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore decode from registered state only
  logic w_eject;
  assign w_eject       = (r_state == S_EJECT);
  assign eject_dime    = w_eject & r_is_dime;
  assign eject_nickel  = w_eject & ~r_is_dime;
  assign req.req_ready = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign fault         = (r_state == S_FAULT);
  assign owed          = r_owed;
  assign nickel_cnt    = r_nick;
  assign dime_cnt      = r_dime;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Bench for change_dispenser_ctrl: vector table plus directed cases.
// Coin order is scoreboarded; counts and owed checked per request.
module tb_change_dispenser_ctrl;

  logic       clk;
  logic       reset;
  logic       sense_auto;
  logic       sense_stray;
  logic       coin_sensed;
  logic       refill_nickel;
  logic       refill_dime;
  logic       eject_nickel;
  logic       eject_dime;
  logic       busy;
  logic       done;
  logic       fault;
  logic [3:0] owed;
  logic [4:0] nickel_cnt;
  logic [4:0] dime_cnt;

  int checks = 0;
  int errors = 0;

  change_dispenser_if u_if ();

  assign coin_sensed = sense_auto | sense_stray;

  change_dispenser_ctrl #(
    .PULSE_CYCLES   (4),
    .TIMEOUT_CYCLES (64),
    .NICKEL_INIT    (15),
    .DIME_INIT      (15)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (u_if.slave),
    .coin_sensed   (coin_sensed),
    .refill_nickel (refill_nickel),
    .refill_dime   (refill_dime),
    .eject_nickel  (eject_nickel),
    .eject_dime    (eject_dime),
    .busy          (busy),
    .done          (done),
    .fault         (fault),
    .owed          (owed),
    .nickel_cnt    (nickel_cnt),
    .dime_cnt      (dime_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard of expected coins: 1 = dime, 0 = nickel
  int q[$];
  int md;
  int mn;
  bit sense_en;
  bit aborting;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // greedy reference: dimes while owed>=2, else nickels
  task automatic model_push(input int amt);
    int o;
    o = amt;
    while (o > 0) begin
      if (o >= 2 && md > 0) begin
        q.push_back(1); md--; o -= 2;
      end else if (mn > 0) begin
        q.push_back(0); mn--; o -= 1;
      end else begin
        break;
      end
    end
  endtask

  // eject monitor and coin-sensor responder
  initial begin
    bit prev;
    int width;
    int sdly;
    int e;
    prev = 0; width = 0; sdly = 0;
    sense_auto = 1'b0;
    forever begin
      @(negedge clk);
      sense_auto = 1'b0;
      if (aborting) begin
        prev = 0; width = 0; sdly = 0;
      end else begin
        if (eject_nickel && eject_dime)
          chk("both_eject", 1, 0);
        if (sdly == 1) begin
          if (sense_en) sense_auto = 1'b1;
          sdly = 0;
        end
        if ((eject_nickel || eject_dime) && !prev) begin
          width = 1;
          if (q.size() == 0) begin
            chk("unexpected_eject", 1, 0);
          end else begin
            e = q.pop_front();
            chk("coin_type", int'(eject_dime), e);
          end
        end else if (eject_nickel || eject_dime) begin
          width++;
        end else if (prev) begin
          chk("pulse_width", width, 4);
          sdly = 1;
        end
        prev = eject_nickel | eject_dime;
      end
    end
  end

  task automatic do_reset();
    aborting = 1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    aborting = 0;
    md = 15; mn = 15;
    q.delete();
  endtask

  task automatic send(input logic [3:0] amt);
    @(negedge clk);
    chk("req_ready_before", int'(u_if.req_ready), 1);
    u_if.req_valid = 1'b1;
    u_if.req_amt   = amt;
    @(negedge clk);
    u_if.req_valid = 1'b0;
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (!done && !fault && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("end_timeout", 1, 0);
  endtask

  task automatic check_end(
    input string nm, input int ef, input int eo,
    input int ed, input int en
  );
    chk({nm, "_fault"}, int'(fault), ef);
    chk({nm, "_done"}, int'(done), 1 - ef);
    chk({nm, "_owed"}, int'(owed), eo);
    chk({nm, "_dime"}, int'(dime_cnt), ed);
    chk({nm, "_nick"}, int'(nickel_cnt), en);
    chk({nm, "_sb_empty"}, q.size(), 0);
    if (ef == 0) begin
      @(negedge clk);
      chk({nm, "_done_1cyc"}, int'(done), 0);
      chk({nm, "_ready_after"}, int'(u_if.req_ready), 1);
    end
  endtask

  typedef struct {
    logic [3:0] amt;
    int         e_owed;
    int         e_dime;
    int         e_nick;
  } vec_t;

  vec_t vt[5];

  initial begin
    int n;
    vt[0] = '{4'd7,  0, 12, 14};
    vt[1] = '{4'd15, 0, 5,  13};
    vt[2] = '{4'd8,  0, 1,  13};
    vt[3] = '{4'd6,  0, 0,  9};
    vt[4] = '{4'd9,  0, 0,  0};

    u_if.req_valid = 1'b0;
    u_if.req_amt   = 4'd0;
    refill_nickel  = 1'b0;
    refill_dime    = 1'b0;
    sense_stray    = 1'b0;
    sense_en       = 1;
    reset          = 1'b1;
    do_reset();

    chk("rst_ready", int'(u_if.req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_eject", int'(eject_nickel | eject_dime), 0);
    chk("rst_owed", int'(owed), 0);
    chk("rst_nick", int'(nickel_cnt), 15);
    chk("rst_dime", int'(dime_cnt), 15);

    for (int i = 0; i < 5; i++) begin
      model_push(int'(vt[i].amt));
      send(vt[i].amt);
      wait_end(n);
      check_end($sformatf("vec%0d", i), 0, vt[i].e_owed,
                vt[i].e_dime, vt[i].e_nick);
    end

    // refill dimes in IDLE, then request 3 with no nickels
    @(negedge clk);
    refill_dime = 1'b1;
    @(negedge clk);
    refill_dime = 1'b0;
    md = 15;
    chk("idle_refill_dime", int'(dime_cnt), 15);
    model_push(3);
    send(4'd3);
    wait_end(n);
    check_end("nick_fault", 1, 1, 14, 0);
    @(negedge clk);
    refill_nickel = 1'b1;
    mn = 15;
    model_push(1);
    @(negedge clk);
    refill_nickel = 1'b0;
    wait_end(n);
    check_end("resume", 0, 0, 14, 14);

    // timeout: no sensor ack
    do_reset();
    sense_en = 0;
    q.push_back(1);
    send(4'd2);
    n = 0;
    while (!eject_dime && n < 100) begin
      @(negedge clk); n++;
    end
    while (eject_dime && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) chk("tmo_eject_wait", 1, 0);
    n = 0;
    while (!fault && n < 200) begin
      @(negedge clk); n++;
    end
    chk("tmo_cycles", n, 64);
    chk("tmo_fault", int'(fault), 1);
    chk("tmo_owed", int'(owed), 2);
    chk("tmo_dime", int'(dime_cnt), 15);
    chk("tmo_sb_empty", q.size(), 0);
    sense_en = 1;
    do_reset();

    // zero amount: done the cycle after acceptance
    send(4'd0);
    chk("zero_done", int'(done), 1);
    chk("zero_eject", int'(eject_nickel | eject_dime), 0);
    @(negedge clk);
    chk("zero_ready", int'(u_if.req_ready), 1);

    // stray sense in IDLE
    sense_stray = 1'b1;
    @(negedge clk);
    sense_stray = 1'b0;
    @(negedge clk);
    chk("stray_idle_nick", int'(nickel_cnt), 15);
    chk("stray_idle_dime", int'(dime_cnt), 15);
    chk("stray_idle_busy", int'(busy), 0);

    model_push(2);
    send(4'd2);
    wait_end(n);
    check_end("amt2", 0, 0, 14, 15);

    // stray sense and refill_dime during EJECT
    model_push(1);
    send(4'd1);
    n = 0;
    while (!eject_nickel && n < 100) begin
      @(negedge clk); n++;
    end
    sense_stray = 1'b1;
    refill_dime = 1'b1;
    @(negedge clk);
    sense_stray = 1'b0;
    refill_dime = 1'b0;
    chk("stray_ej_nick", int'(nickel_cnt), 15);
    chk("stray_ej_dime", int'(dime_cnt), 14);
    chk("stray_ej_eject", int'(eject_nickel), 1);
    wait_end(n);
    check_end("stray_ej", 0, 0, 14, 14);

    // reset in the middle of an eject
    model_push(5);
    send(4'd5);
    n = 0;
    while (!eject_dime && n < 100) begin
      @(negedge clk); n++;
    end
    aborting = 1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_eject", int'(eject_nickel | eject_dime), 0);
    chk("mid_rst_ready", int'(u_if.req_ready), 1);
    chk("mid_rst_owed", int'(owed), 0);
    chk("mid_rst_nick", int'(nickel_cnt), 15);
    chk("mid_rst_dime", int'(dime_cnt), 15);
    reset = 1'b0;
    q.delete();
    @(negedge clk);
    aborting = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
